// File: rtl/aes_decrypt_iterative_pkg.sv
// rtl/aes_decrypt_iterative_pkg.sv - AES-128 inverse cipher shared types, FSM encodings and GF(2^8) helpers
package aes_decrypt_iterative_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_KEYEXP = 2'd1,
      ST_READY  = 2'd2,
      ST_ROUND  = 2'd3
   } state_e;

   function automatic logic [7:0] rotl8(input logic [7:0] x, input int unsigned n);
      logic [15:0] d;
      d = {x, x} << n;
      return d[15:8];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // Multiplicative inverse as x^254; maps 0 to 0 as the S-box requires.
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] r;
      logic [7:0] p;
      r = 8'h01;
      p = x;
      for (int i = 1; i < 8; i++) begin
         p = gmul(p, p);
         r = gmul(r, p);
      end
      return r;
   endfunction

   function automatic logic [7:0] aes_sbox(input logic [7:0] x);
      logic [7:0] b;
      b = gf_inv(x);
      return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
   endfunction

   function automatic logic [7:0] aes_inv_sbox(input logic [7:0] s);
      return gf_inv(rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05);
   endfunction

   function automatic logic [7:0] aes_rcon(input logic [3:0] idx);
      logic [7:0] r;
      case (idx)
         4'd1:    r = 8'h01;
         4'd2:    r = 8'h02;
         4'd3:    r = 8'h04;
         4'd4:    r = 8'h08;
         4'd5:    r = 8'h10;
         4'd6:    r = 8'h20;
         4'd7:    r = 8'h40;
         4'd8:    r = 8'h80;
         4'd9:    r = 8'h1b;
         4'd10:   r = 8'h36;
         default: r = 8'h00;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/aes_inv_round.sv
// rtl/aes_inv_round.sv - combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, optional InvMixColumns
module aes_inv_round
   import aes_decrypt_iterative_pkg::*;
(
   input  logic [127:0] data_in,
   input  logic [127:0] round_key,
   input  logic         last,
   output logic [127:0] data_out
);

   logic [7:0]   in_b  [16];
   logic [7:0]   ark_b [16];
   logic [127:0] mixed;

   // Byte b = row + 4*col, byte 0 in the top bits; row r rotates right by r.
   always_comb begin
      for (int b = 0; b < 16; b++) begin
         in_b[b] = data_in[127-8*b -: 8];
      end
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            ark_b[r+4*c] = aes_inv_sbox(in_b[r + 4*((c - r + 4) % 4)])
                           ^ round_key[127-8*(r+4*c) -: 8];
         end
      end
   end

   always_comb begin
      mixed = '0;
      for (int c = 0; c < 4; c++) begin
         mixed[127-8*(4*c)   -: 8] = gmul(ark_b[4*c], 8'h0e) ^ gmul(ark_b[4*c+1], 8'h0b)
                                   ^ gmul(ark_b[4*c+2], 8'h0d) ^ gmul(ark_b[4*c+3], 8'h09);
         mixed[127-8*(4*c+1) -: 8] = gmul(ark_b[4*c], 8'h09) ^ gmul(ark_b[4*c+1], 8'h0e)
                                   ^ gmul(ark_b[4*c+2], 8'h0b) ^ gmul(ark_b[4*c+3], 8'h0d);
         mixed[127-8*(4*c+2) -: 8] = gmul(ark_b[4*c], 8'h0d) ^ gmul(ark_b[4*c+1], 8'h09)
                                   ^ gmul(ark_b[4*c+2], 8'h0e) ^ gmul(ark_b[4*c+3], 8'h0b);
         mixed[127-8*(4*c+3) -: 8] = gmul(ark_b[4*c], 8'h0b) ^ gmul(ark_b[4*c+1], 8'h0d)
                                   ^ gmul(ark_b[4*c+2], 8'h09) ^ gmul(ark_b[4*c+3], 8'h0e);
      end
   end

   always_comb begin
      data_out = mixed;
      if (last) begin
         for (int b = 0; b < 16; b++) begin
            data_out[127-8*b -: 8] = ark_b[b];
         end
      end
   end

endmodule

// File: rtl/aes_decrypt_iterative.sv
// rtl/aes_decrypt_iterative.sv - iterative AES-128 decryptor, one round per clock; AES_DEC_ZEROIZE_EN clears key/state/output storage
module aes_decrypt_iterative
   import aes_decrypt_iterative_pkg::*;
#(
   parameter int DATA_W    = 128,
   parameter int KEY_LEN   = 128,
   parameter int NO_ROUNDS = 10
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cipherkey_valid_in,
   input  logic [KEY_LEN-1:0] cipher_key,
   input  logic               data_valid_in,
   input  logic [DATA_W-1:0]  cipher_text,
   output logic               ready_out,
   output logic               valid_out,
   output logic [DATA_W-1:0]  plain_text
);

   localparam int CNT_W = $clog2(NO_ROUNDS + 1);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [DATA_W-1:0]  st_q, st_d;
   logic [DATA_W-1:0]  pt_q, pt_d;
   logic               valid_q, valid_d;
   logic [KEY_LEN-1:0] rk_q [0:NO_ROUNDS];

   logic               rk_load, rk_exp, accept;
   logic [127:0]       rk_prev, rk_next, round_out;
   logic [31:0]        rot_w, sub_w, w0_n, w1_n, w2_n, w3_n;

   assign ready_out  = (state_q == ST_READY);
   assign valid_out  = valid_q;
   assign plain_text = pt_q;
   assign accept     = data_valid_in & ready_out & ~cipherkey_valid_in;

   // Key schedule g-function on the previous round key, Rcon indexed by the round number.
   assign rk_prev = rk_q[cnt_q - 1'b1];
   assign rot_w   = {rk_prev[23:0], rk_prev[31:24]};
   assign sub_w   = {aes_sbox(rot_w[31:24]), aes_sbox(rot_w[23:16]),
                     aes_sbox(rot_w[15:8]),  aes_sbox(rot_w[7:0])};
   assign w0_n    = rk_prev[127:96] ^ sub_w ^ {aes_rcon(cnt_q), 24'h000000};
   assign w1_n    = rk_prev[95:64] ^ w0_n;
   assign w2_n    = rk_prev[63:32] ^ w1_n;
   assign w3_n    = rk_prev[31:0]  ^ w2_n;
   assign rk_next = {w0_n, w1_n, w2_n, w3_n};

   aes_inv_round u_inv_round (
      .data_in   (st_q),
      .round_key (rk_q[cnt_q]),
      .last      (cnt_q == '0),
      .data_out  (round_out)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      st_d    = st_q;
      valid_d = 1'b0;
      rk_load = 1'b0;
      rk_exp  = 1'b0;
`ifdef AES_DEC_ZEROIZE_EN
      pt_d    = '0;
`else
      pt_d    = pt_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (cipherkey_valid_in) begin
               rk_load = 1'b1;
               cnt_d   = CNT_W'(1);
               state_d = ST_KEYEXP;
            end
         end
         ST_KEYEXP: begin
            rk_exp = 1'b1;
            if (cnt_q == CNT_W'(NO_ROUNDS)) begin
               state_d = ST_READY;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_READY: begin
            if (cipherkey_valid_in) begin
               rk_load = 1'b1;
               cnt_d   = CNT_W'(1);
               state_d = ST_KEYEXP;
            end else if (accept) begin
               st_d    = cipher_text ^ rk_q[NO_ROUNDS];
               cnt_d   = CNT_W'(NO_ROUNDS - 1);
               state_d = ST_ROUND;
            end
         end
         default: begin
            if (cnt_q != '0) begin
               st_d  = round_out;
               cnt_d = cnt_q - 1'b1;
            end else begin
               pt_d    = round_out;
               valid_d = 1'b1;
               state_d = ST_READY;
            end
         end
      endcase
`ifdef AES_DEC_ZEROIZE_EN
      if (rk_load) st_d = '0;
`endif
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         pt_q    <= '0;
`ifdef AES_DEC_ZEROIZE_EN
         st_q    <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         pt_q    <= pt_d;
         st_q    <= st_d;
      end
   end

   always_ff @(posedge clk) begin
`ifdef AES_DEC_ZEROIZE_EN
      if (!reset) begin
         for (int i = 0; i <= NO_ROUNDS; i++) rk_q[i] <= '0;
      end else begin
         if (rk_load) begin
            for (int i = 1; i <= NO_ROUNDS; i++) rk_q[i] <= '0;
            rk_q[0] <= cipher_key;
         end
         if (rk_exp) rk_q[cnt_q] <= rk_next;
      end
`else
      if (reset) begin
         if (rk_load) rk_q[0] <= cipher_key;
         if (rk_exp)  rk_q[cnt_q] <= rk_next;
      end
`endif
   end

endmodule

// File: tb/tb_aes_decrypt_iterative.sv
// tb/tb_aes_decrypt_iterative.sv - directed vector bench for aes_decrypt_iterative
module tb_aes_decrypt_iterative;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         cipherkey_valid_in = 1'b0;
   logic [127:0] cipher_key = '0;
   logic         data_valid_in = 1'b0;
   logic [127:0] cipher_text = '0;
   logic         ready_out;
   logic         valid_out;
   logic [127:0] plain_text;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [127:0] key;
      logic [127:0] ct;
      logic [127:0] pt;
   } vec_t;

   vec_t vecs [3];

   always #5 clk = ~clk;

   aes_decrypt_iterative dut (
      .clk                (clk),
      .reset              (reset),
      .cipherkey_valid_in (cipherkey_valid_in),
      .cipher_key         (cipher_key),
      .data_valid_in      (data_valid_in),
      .cipher_text        (cipher_text),
      .ready_out          (ready_out),
      .valid_out          (valid_out),
      .plain_text         (plain_text)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic load_key(input logic [127:0] k, input logic with_data);
      int   n;
      logic seen;
      cipher_key         = k;
      cipherkey_valid_in = 1'b1;
      data_valid_in      = with_data;
      step();
      cipherkey_valid_in = 1'b0;
      data_valid_in      = 1'b0;
      n    = 0;
      seen = 1'b0;
      while (!ready_out && n < 50) begin
         step();
         n++;
         if (valid_out) seen = 1'b1;
      end
      chk("key_ready_latency", 128'(n), 128'd10);
      chk("key_no_valid", 128'(seen), 128'd0);
   endtask

   task automatic decrypt(input int i);
      int n;
      chk("dec_ready_before", 128'(ready_out), 128'd1);
      cipher_text   = vecs[i].ct;
      data_valid_in = 1'b1;
      step();
      data_valid_in = 1'b0;
      n = 0;
      while (!valid_out && n < 50) begin
         step();
         n++;
      end
      chk("dec_latency", 128'(n), 128'd10);
      chk("dec_plain_text", plain_text, vecs[i].pt);
      chk("dec_ready_with_valid", 128'(ready_out), 128'd1);
      step();
      chk("dec_valid_pulse", 128'(valid_out), 128'd0);
`ifdef AES_DEC_ZEROIZE_EN
      chk("dec_zeroized", plain_text, 128'd0);
`else
      chk("dec_hold", plain_text, vecs[i].pt);
`endif
   endtask

   initial begin
      int   n;
      int   pulses;
      int   last_pulse;
      int   bad_space;
      int   bad_pt;
      int   bad_ready;
      logic seen;

      vecs[0] = '{128'h000102030405060708090a0b0c0d0e0f,
                  128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                  128'h00112233445566778899aabbccddeeff};
      vecs[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
                  128'h3925841d02dc09fbdc118597196a0b32,
                  128'h3243f6a8885a308d313198a2e0370734};
      vecs[2] = '{128'h00000000000000000000000000000000,
                  128'h66e94bd4ef8a2c3b884cfa59ca342b2e,
                  128'h00000000000000000000000000000000};

      step();
      step();
      chk("reset_ready", 128'(ready_out), 128'd0);
      chk("reset_valid", 128'(valid_out), 128'd0);
      chk("reset_plain_text", plain_text, 128'd0);
      reset = 1'b1;

      data_valid_in = 1'b1;
      cipher_text   = vecs[0].ct;
      seen = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step();
         if (ready_out || valid_out) seen = 1'b1;
      end
      data_valid_in = 1'b0;
      chk("idle_ignores_data", 128'(seen), 128'd0);

      for (int i = 0; i < 3; i++) begin
         load_key(vecs[i].key, 1'b0);
         decrypt(i);
      end

      // Continuous stream under test-2 key: one block every 11 cycles.
      load_key(vecs[1].key, 1'b0);
      cipher_text   = vecs[1].ct;
      data_valid_in = 1'b1;
      pulses = 0; last_pulse = 0; bad_space = 0; bad_pt = 0; bad_ready = 0;
      for (int s = 1; s <= 110; s++) begin
         step();
         if (ready_out !== valid_out) bad_ready++;
         if (valid_out) begin
            pulses++;
            if (s - last_pulse != 11) bad_space++;
            if (plain_text !== vecs[1].pt) bad_pt++;
            last_pulse = s;
         end
      end
      data_valid_in = 1'b0;
      chk("stream_pulses", 128'(pulses), 128'd10);
      chk("stream_spacing", 128'(bad_space), 128'd0);
      chk("stream_plain_text", 128'(bad_pt), 128'd0);
      chk("stream_ready_only_with_valid", 128'(bad_ready), 128'd0);
      step();

      // Key during ROUND is ignored; block finishes with old key.
      cipher_text   = vecs[1].ct;
      data_valid_in = 1'b1;
      step();
      data_valid_in = 1'b0;
      step();
      step();
      cipher_key         = vecs[0].key;
      cipherkey_valid_in = 1'b1;
      step();
      cipherkey_valid_in = 1'b0;
      n = 3;
      while (!valid_out && n < 50) begin
         step();
         n++;
      end
      chk("round_key_ignored_latency", 128'(n), 128'd10);
      chk("round_key_ignored_pt", plain_text, vecs[1].pt);
      step();
      chk("round_key_ignored_ready", 128'(ready_out), 128'd1);

      // Key and data together in READY: key wins.
      cipher_text = vecs[1].ct;
      load_key(vecs[0].key, 1'b1);
      decrypt(0);

      // Reset while the round counter is at 5.
      cipher_text   = vecs[0].ct;
      data_valid_in = 1'b1;
      step();
      data_valid_in = 1'b0;
      repeat (4) step();
      reset = 1'b0;
      step();
      reset = 1'b1;
      chk("midround_reset_ready", 128'(ready_out), 128'd0);
      chk("midround_reset_valid", 128'(valid_out), 128'd0);
      chk("midround_reset_plain_text", plain_text, 128'd0);
      data_valid_in = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 20; k++) begin
         step();
         if (ready_out || valid_out) seen = 1'b1;
      end
      data_valid_in = 1'b0;
      chk("post_reset_ignores_data", 128'(seen), 128'd0);
      load_key(vecs[0].key, 1'b0);
      decrypt(0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
